// File: rtl/spi_target_lite_pkg.sv
// spi_target_lite_pkg
//   Shared types and helpers for the SPI mode-0 target.
//   - state_t   : two-state transaction FSM encoding
//   - MsbFirst  : SPI bit order (mode 0 here is MSB first)
//   - shift_in / shift_out / out_bit : bit-order aware shift helpers used by
//     both the RX and TX shift registers so the order is set in one place.
package spi_target_lite_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  localparam logic MsbFirst = 1'b1;

  // Append one received bit to a partial byte.
  function automatic logic [7:0] shift_in(input logic [7:0] sh, input logic b);
    return MsbFirst ? {sh[6:0], b} : {b, sh[7:1]};
  endfunction

  // Advance the transmit byte so the next bit sits in the output position.
  function automatic logic [7:0] shift_out(input logic [7:0] sh);
    return MsbFirst ? {sh[6:0], 1'b0} : {1'b0, sh[7:1]};
  endfunction

  // Bit currently presented on the serial output.
  function automatic logic out_bit(input logic [7:0] sh);
    return MsbFirst ? sh[7] : sh[0];
  endfunction

endpackage

// File: rtl/spi_target_lite_fifo.sv
// spi_target_lite_fifo
//   Small synchronous FIFO for received bytes. Any Depth >= 2 is supported
//   (pointers wrap explicitly, so Depth need not be a power of two).
//   A push on a full FIFO is accepted only if a pop happens in the same cycle;
//   otherwise it is ignored and the contents are untouched.
// Ports
//   clk_i, rst_i  : clock, synchronous active-high reset
//   push_i/data_i : write request and data
//   pop_i         : remove head entry (ignored when empty)
//   data_o        : head entry (undefined when empty)
//   full_o/empty_o/count_o : occupancy status
module spi_target_lite_fifo #(
  parameter  int Depth = 4,
  parameter  int Width = 8,
  localparam int PW    = $clog2(Depth),
  localparam int CW    = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [Width-1:0] r_mem [Depth];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_do_pop;
  logic             w_do_push;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o    = (r_cnt == CW'(Depth));
  assign empty_o   = (r_cnt == '0);
  assign count_o   = r_cnt;
  assign data_o    = r_mem[r_rd];
  assign w_do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_do_push = push_i & (~full_o | w_do_pop);

  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= nxt(r_wr);
      if (w_do_pop)  r_rd <= nxt(r_rd);
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/spi_target_lite.sv
// spi_target_lite
//   SPI mode-0 target. All SPI pins are oversampled by clk_i (>= 8x sck):
//   2-flop synchronisers plus one delay stage on sck/csb give single-cycle
//   edge strobes. Received bytes go to an RX FIFO; transmit bytes come from a
//   one-entry holding register, with IdleByte substituted when it is empty.
// Ports
//   clk_i, rst_i          : clock, synchronous active-high reset
//   sck_i, csb_i, sdi_i   : SPI host clock, chip select (low), host data
//   sdo_o, sdo_en_o       : target data and its output enable
//   rx_data_o/valid/ready : RX FIFO head, ready/valid handshake
//   tx_data_i/valid/ready : TX holding register load, ready/valid handshake
//   busy_o                : synchronised chip select active
//   rx_overflow_o         : pulse, received byte dropped (FIFO full)
//   tx_underflow_o        : pulse, IdleByte loaded instead of TX data
module spi_target_lite
  import spi_target_lite_pkg::*;
#(
  parameter int         RxDepth  = 4,
  parameter logic [7:0] IdleByte = 8'hFF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sck_i,
  input  logic       csb_i,
  input  logic       sdi_i,
  output logic       sdo_o,
  output logic       sdo_en_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       busy_o,
  output logic       rx_overflow_o,
  output logic       tx_underflow_o
);

  localparam int CW = $clog2(RxDepth + 1);

  // synchronisers and edge detection
  logic r_sck_s1, r_sck_s2, r_sck_d;
  logic r_csb_s1, r_csb_s2, r_csb_d;
  logic r_sdi_s1, r_sdi_s2;
  logic [1:0] r_settle;
  logic r_armed;
  logic w_sck_rise, w_sck_fall, w_csb_rise, w_csb_fall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sck_s1 <= 1'b0;
      r_sck_s2 <= 1'b0;
      r_sck_d  <= 1'b0;
      r_csb_s1 <= 1'b1;
      r_csb_s2 <= 1'b1;
      r_csb_d  <= 1'b1;
      r_sdi_s1 <= 1'b0;
      r_sdi_s2 <= 1'b0;
      r_settle <= 2'd0;
      r_armed  <= 1'b0;
    end else begin
      r_sck_s1 <= sck_i;
      r_sck_s2 <= r_sck_s1;
      r_sck_d  <= r_sck_s2;
      r_csb_s1 <= csb_i;
      r_csb_s2 <= r_csb_s1;
      r_csb_d  <= r_csb_s2;
      r_sdi_s1 <= sdi_i;
      r_sdi_s2 <= r_sdi_s1;
      // The reset-loaded idle levels would fake a csb fall if the host holds
      // csb low across reset. Only arm once a real high level has reached
      // the second sync stage, so a transaction needs a fresh csb fall.
      if (r_settle != 2'd2) r_settle <= r_settle + 2'd1;
      if (r_settle == 2'd2 && r_csb_s2) r_armed <= 1'b1;
    end
  end

  assign w_sck_rise =  r_sck_s2 & ~r_sck_d;
  assign w_sck_fall = ~r_sck_s2 &  r_sck_d;
  assign w_csb_rise =  r_csb_s2 & ~r_csb_d;
  assign w_csb_fall = ~r_csb_s2 &  r_csb_d & r_armed;
  assign busy_o     = ~r_csb_s2;

  // FSM
  state_t r_state, w_state_nxt;
  logic   w_enter;   // csb fall accepted: byte boundary at start
  logic   w_active;  // active and not ending this cycle

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_enter     = 1'b0;
    w_active    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_csb_fall) begin
          w_state_nxt = ST_ACTIVE;
          w_enter     = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (w_csb_rise) w_state_nxt = ST_IDLE;
        else            w_active    = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // shifters, bit counter, TX holding register
  logic [2:0] r_bitcnt;
  logic [7:0] r_rx_sh;
  logic [7:0] r_tx_sh;
  logic [7:0] r_hold;
  logic       r_hold_full;
  logic       r_rx_ovf;
  logic       r_tx_und;

  logic       w_rx_shift, w_byte_done, w_tx_load, w_tx_shift, w_hold_cap;
  logic [7:0] w_rx_byte, w_load_byte;

  logic       w_fifo_full, w_fifo_empty, w_pop;
  logic [7:0] w_fifo_data;
  logic [CW-1:0] w_fifo_cnt;

  assign w_rx_shift  = w_active & w_sck_rise;
  assign w_byte_done = w_rx_shift & (r_bitcnt == 3'd7);
  assign w_rx_byte   = shift_in(r_rx_sh, r_sdi_s2);
  assign w_tx_load   = w_enter | w_byte_done;
  // At count 0 the fall follows a fresh load; its first bit is already out.
  assign w_tx_shift  = w_active & w_sck_fall & (r_bitcnt != 3'd0);
  assign w_load_byte = r_hold_full ? r_hold : IdleByte;
  assign w_hold_cap  = tx_valid_i & ~r_hold_full;
  assign w_pop       = (w_fifo_cnt != '0) & rx_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bitcnt    <= 3'd0;
      r_rx_sh     <= 8'd0;
      r_tx_sh     <= 8'd0;
      r_hold      <= 8'd0;
      r_hold_full <= 1'b0;
      r_rx_ovf    <= 1'b0;
      r_tx_und    <= 1'b0;
    end else begin
      if (w_enter)         r_bitcnt <= 3'd0;
      else if (w_rx_shift) r_bitcnt <= r_bitcnt + 3'd1;

      if (w_rx_shift) r_rx_sh <= w_rx_byte;

      if (w_tx_load)       r_tx_sh <= w_load_byte;
      else if (w_tx_shift) r_tx_sh <= shift_out(r_tx_sh);

      // A capture only happens when empty, so a same-cycle load has already
      // taken IdleByte and the newly captured byte stays held.
      if (w_hold_cap) begin
        r_hold      <= tx_data_i;
        r_hold_full <= 1'b1;
      end else if (w_tx_load && r_hold_full) begin
        r_hold_full <= 1'b0;
      end

      r_tx_und <= w_tx_load & ~r_hold_full;
      r_rx_ovf <= w_byte_done & w_fifo_full & ~w_pop;
    end
  end

  spi_target_lite_fifo #(
    .Depth (RxDepth),
    .Width (8)
  ) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_byte_done),
    .data_i  (w_rx_byte),
    .pop_i   (w_pop),
    .data_o  (w_fifo_data),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .count_o (w_fifo_cnt)
  );

  assign sdo_en_o       = (r_state == ST_ACTIVE);
  assign sdo_o          = sdo_en_o & out_bit(r_tx_sh);
  assign rx_valid_o     = ~w_fifo_empty;
  assign rx_data_o      = w_fifo_empty ? 8'd0 : w_fifo_data;
  assign tx_ready_o     = ~r_hold_full;
  assign rx_overflow_o  = r_rx_ovf;
  assign tx_underflow_o = r_tx_und;

endmodule

// File: tb/tb_spi_target_lite.sv
module tb_spi_target_lite;

  logic       clk = 1'b0;
  logic       rst, sck, csb, sdi;
  logic       sdo, sdo_en;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, busy, rx_ovf, tx_und;

  int n_total = 0;
  int n_pass  = 0;
  int ovf_cnt = 0;
  int und_cnt = 0;

  always #5 clk = ~clk;

  spi_target_lite #(.RxDepth(4), .IdleByte(8'hFF)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .sck_i          (sck),
    .csb_i          (csb),
    .sdi_i          (sdi),
    .sdo_o          (sdo),
    .sdo_en_o       (sdo_en),
    .rx_data_o      (rx_data),
    .rx_valid_o     (rx_valid),
    .rx_ready_i     (rx_ready),
    .tx_data_i      (tx_data),
    .tx_valid_i     (tx_valid),
    .tx_ready_o     (tx_ready),
    .busy_o         (busy),
    .rx_overflow_o  (rx_ovf),
    .tx_underflow_o (tx_und)
  );

  // pulse counters, sampled away from the active edge
  always @(negedge clk) begin
    if (rx_ovf) ovf_cnt++;
    if (tx_und) und_cnt++;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic csb_low();
    csb = 1'b0;
    wait_clk(8);
  endtask

  task automatic csb_high();
    wait_clk(4);
    csb = 1'b1;
    wait_clk(8);
  endtask

  // Mode-0 host: data set while sck low, both sides sample on the rise.
  // sck half period is 4 clk cycles (clk = 8x sck).
  task automatic xfer(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
    miso = 8'd0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      sdi = mosi[i];
      wait_clk(4);
      sck = 1'b1;
      miso[i] = sdo;
      wait_clk(4);
      sck = 1'b0;
    end
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, 8'(rx_valid), 8'd1);
    check(tag, rx_data, exp);
    rx_ready = 1'b1;
    wait_clk(1);
    rx_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] m1, m2;
    int base;
    rst = 1'b1; sck = 1'b0; csb = 1'b1; sdi = 1'b0;
    rx_ready = 1'b0; tx_data = 8'd0; tx_valid = 1'b0;

    // reset state
    wait_clk(3);
    check("rst_sdo",     8'(sdo),      8'd0);
    check("rst_sdo_en",  8'(sdo_en),   8'd0);
    check("rst_rx_valid",8'(rx_valid), 8'd0);
    check("rst_rx_data", rx_data,      8'd0);
    check("rst_tx_ready",8'(tx_ready), 8'd1);
    check("rst_busy",    8'(busy),     8'd0);
    check("rst_pulses",  {6'd0, rx_ovf, tx_und}, 8'd0);
    rst = 1'b0;
    wait_clk(5);

    // single byte, no TX data: IdleByte returned, one underflow at entry
    base = und_cnt;
    csb_low();
    check("t1_busy",   8'(busy),   8'd1);
    check("t1_sdo_en", 8'(sdo_en), 8'd1);
    check("t1_und",    8'(und_cnt - base), 8'd1);
    xfer(8'hA5, 8, m1);
    csb_high();
    check("t1_miso",   m1, 8'hFF);
    check("t1_sdo_en_off", 8'(sdo_en), 8'd0);
    check("t1_sdo_off",    8'(sdo),    8'd0);
    pop_check("t1_rx", 8'hA5);
    check("t1_empty", 8'(rx_valid), 8'd0);

    // preloaded TX byte then idle fill
    tx_data = 8'h3C; tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
    check("t2_txrdy_held", 8'(tx_ready), 8'd0);
    wait_clk(3);
    check("t2_txrdy_still", 8'(tx_ready), 8'd0);
    csb_low();
    check("t2_txrdy_loaded", 8'(tx_ready), 8'd1);
    xfer(8'h11, 8, m1);
    xfer(8'h22, 8, m2);
    csb_high();
    check("t2_miso0", m1, 8'h3C);
    check("t2_miso1", m2, 8'hFF);
    pop_check("t2_rx0", 8'h11);
    pop_check("t2_rx1", 8'h22);

    // overflow: 5 bytes into a 4-deep FIFO with no consumer
    base = ovf_cnt;
    csb_low();
    for (int b = 1; b <= 5; b++) xfer(8'(b), 8, m1);
    csb_high();
    check("t3_ovf", 8'(ovf_cnt - base), 8'd1);
    pop_check("t3_rx0", 8'h01);
    pop_check("t3_rx1", 8'h02);
    pop_check("t3_rx2", 8'h03);
    pop_check("t3_rx3", 8'h04);
    check("t3_empty", 8'(rx_valid), 8'd0);

    // full FIFO with a pop in the very cycle of the 5th push
    base = ovf_cnt;
    csb_low();
    xfer(8'h10, 8, m1);
    xfer(8'h20, 8, m1);
    xfer(8'h30, 8, m1);
    xfer(8'h40, 8, m1);
    xfer(8'h50, 7, m1);
    sdi = 1'b0;
    wait_clk(4);
    sck = 1'b1;
    wait_clk(2);
    rx_ready = 1'b1;   // covers exactly the push edge
    wait_clk(1);
    rx_ready = 1'b0;
    wait_clk(1);
    sck = 1'b0;
    csb_high();
    check("t4_no_ovf", 8'(ovf_cnt - base), 8'd0);
    pop_check("t4_rx0", 8'h20);
    pop_check("t4_rx1", 8'h30);
    pop_check("t4_rx2", 8'h40);
    pop_check("t4_rx3", 8'h50);
    check("t4_empty", 8'(rx_valid), 8'd0);

    // aborted byte after 5 bits, then a clean one
    csb_low();
    xfer(8'hE7, 5, m1);
    csb_high();
    check("t5_sdo_en", 8'(sdo_en),   8'd0);
    check("t5_no_push",8'(rx_valid), 8'd0);
    csb_low();
    xfer(8'h5A, 8, m1);
    csb_high();
    pop_check("t5_rx", 8'h5A);

    // reset mid-byte with csb held low
    csb_low();
    xfer(8'h77, 4, m1);
    rst = 1'b1;
    wait_clk(2);
    check("t6_sdo",      8'(sdo),      8'd0);
    check("t6_sdo_en",   8'(sdo_en),   8'd0);
    check("t6_rx_valid", 8'(rx_valid), 8'd0);
    check("t6_rx_data",  rx_data,      8'd0);
    check("t6_tx_ready", 8'(tx_ready), 8'd1);
    check("t6_busy",     8'(busy),     8'd0);
    check("t6_pulses",   {6'd0, rx_ovf, tx_und}, 8'd0);
    rst = 1'b0;
    wait_clk(10);
    check("t6_no_restart", 8'(sdo_en), 8'd0);
    csb = 1'b1;
    wait_clk(8);
    csb_low();
    xfer(8'hC3, 8, m1);
    csb_high();
    pop_check("t6_rx", 8'hC3);
    check("t6_empty", 8'(rx_valid), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spi_target_lite.md
SPI_TARGET_LITE -- requirements
Module: spi_target_lite

Interface
REQ-001 Parameter RxDepth, default 4: RX FIFO depth in bytes; legal values 2..16.
REQ-002 Parameter IdleByte, default 8'hFF: byte shifted out when no TX data is available.
REQ-003 clk_i  input  1  single block clock; must run at least 8x the sck_i frequency.
REQ-004 rst_i  input  1  reset; synchronous, active-high.
REQ-005 sck_i  input  1  SPI clock from the bus host, mode 0 (CPOL=0, CPHA=0); asynchronous to clk_i.
REQ-006 csb_i  input  1  chip select, active-low; asynchronous to clk_i.
REQ-007 sdi_i  input  1  host-to-target serial data (host sd[0]).
REQ-008 sdo_o  output  1  target-to-host serial data (host sd[1]).
REQ-009 sdo_en_o  output  1  output enable for sdo_o; high only while the transaction is active.
REQ-010 rx_data_o  output  8  head byte of the RX FIFO.
REQ-011 rx_valid_o  output  1  rx_data_o is valid.
REQ-012 rx_ready_i  input  1  consumer accepts the head byte.
REQ-013 tx_data_i  input  8  next byte to transmit.
REQ-014 tx_valid_i  input  1  tx_data_i is valid.
REQ-015 tx_ready_o  output  1  TX holding register is empty.
REQ-016 busy_o  output  1  synchronised csb is active (low).
REQ-017 rx_overflow_o  output  1  one-cycle pulse: a received byte was dropped because the FIFO was full.
REQ-018 tx_underflow_o  output  1  one-cycle pulse: IdleByte was loaded in place of real TX data.

Function
REQ-019 sck_i, csb_i and sdi_i SHALL each pass through a 2-flop synchroniser; a further register on sck and csb SHALL provide single-cycle rise and fall strobes.
REQ-020 The FSM SHALL have two states: IDLE and ACTIVE; IDLE->ACTIVE on the csb fall strobe; ACTIVE->IDLE on the csb rise strobe.
REQ-021 On entry to ACTIVE: clear the 3-bit bit counter, load the TX shift register, assert sdo_en_o, and drive the byte MSB on sdo_o in the same cycle.
REQ-022 On each sck rise strobe in ACTIVE, the RX shift register SHALL shift in the synchronised sdi MSB-first, and the bit counter SHALL increment modulo 8.
REQ-023 On the 8th rise strobe (counter 7->0), the completed byte SHALL be pushed to the RX FIFO in that cycle; rx_valid_o SHALL be high on the following cycle.
REQ-024 If the FIFO is full at a push, the byte SHALL be dropped, FIFO contents left unchanged, and rx_overflow_o pulsed.
REQ-025 An FIFO pop SHALL occur when rx_valid_o && rx_ready_i; a simultaneous push and pop on a full FIFO SHALL succeed without overflow.
REQ-026 On each sck fall strobe in ACTIVE with counter != 0, the TX shift register SHALL shift left and drive the new MSB on sdo_o.
REQ-027 At each byte boundary (ACTIVE entry or 8th rise strobe), the TX shift register SHALL load the holding register if it is full (emptying it); otherwise it SHALL load IdleByte and pulse tx_underflow_o.
REQ-028 The holding register SHALL capture tx_data_i when tx_valid_i && tx_ready_o; a capture and a load in the same cycle SHALL take the byte being loaded and leave the new byte held.
REQ-029 A csb rise strobe mid-byte SHALL discard the partial RX byte without a push, deassert sdo_en_o, and leave the holding register unchanged.
REQ-030 sck strobes in IDLE SHALL be ignored.
REQ-031 sdo_o SHALL be 0 whenever sdo_en_o is low.

Reset
REQ-032 While rst_i is high: FSM=IDLE, FIFO empty, holding register empty, synchronisers loaded with idle levels (sck=0, csb=1).
REQ-033 Output reset values: sdo_o=0, sdo_en_o=0, rx_valid_o=0, rx_data_o=0, tx_ready_o=1, busy_o=0, both pulse outputs 0.
REQ-034 Reset asserted mid-transaction SHALL abort the transaction; after release the block SHALL wait for a fresh csb fall.

Structure
REQ-035 Package spi_target_lite_pkg SHALL hold the FSM state enum and the SPI mode-0 bit-order constant.
REQ-036 The RX FIFO SHALL be the sub-module spi_target_lite_fifo (synchronous reset, depth RxDepth, with full, empty and count outputs).
REQ-037 The synchroniser, edge detection, FSM and shifters SHALL reside in the top module.

Verification
REQ-038 Bench: clk at 8x sck, csb low, host sends 8'hA5 -> rx_data_o=8'hA5, rx_valid_o high; host receives IdleByte 8'hFF; tx_underflow_o pulses once.
REQ-039 Bench: tx_data_i=8'h3C preloaded, host sends 2 bytes -> host receives 8'h3C then 8'hFF; tx_ready_o low until the first load.
REQ-040 Bench: rx_ready_i=0, host sends 5 bytes 8'h01..8'h05 (RxDepth=4) -> FIFO holds 01..04; one rx_overflow_o pulse; draining yields 01,02,03,04.
REQ-041 Bench: csb raised after 5 bits -> no push, sdo_en_o=0; next transaction byte 8'h5A received intact.
REQ-042 Bench: rst_i pulsed mid-byte -> all outputs at reset values; subsequent 8'hC3 received correctly.
REQ-043 Bench: FIFO full with rx_ready_i=1 at the push cycle -> no overflow; byte order preserved.
